// File: rtl/fetch_stage.sv
// fetch_stage: MIPS instruction fetch with PC, one-outstanding imem read, decode handshake and redirect squash
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [31:0] pc_plus4,
    output logic [5:0]  op,
    output logic [5:0]  func
);
    typedef enum logic [1:0] {IDLE, FETCH, WAIT, HOLD} state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic [31:0] r_inst_pc;
    logic        r_drop;
    logic        r_req;
    logic        r_inst_valid;
    logic [31:0] w_redir_pc;

    assign w_redir_pc = redirect_pc & ~32'd3;
    assign imem_req   = r_req;
    assign imem_addr  = r_pc;
    assign inst_valid = r_inst_valid;
    assign inst       = r_inst;
    assign inst_pc    = r_inst_pc;
    assign pc_plus4   = r_inst_pc + 32'd4;
    assign op         = r_inst[31:26];
    assign func       = r_inst[5:0];

    // Fetch FSM; r_req is raised exactly on entry to FETCH so it mirrors that state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_pc         <= RESET_PC;
            r_drop       <= 1'b0;
            r_req        <= 1'b0;
            r_inst_valid <= 1'b0;
            r_inst       <= 32'd0;
            r_inst_pc    <= 32'd0;
        end else begin
            r_req <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_state <= FETCH;
                    r_req   <= 1'b1;
                    if (redirect_valid) r_pc <= w_redir_pc;
                end
                FETCH: begin
                    r_state <= WAIT;
                    if (redirect_valid) begin
                        r_pc   <= w_redir_pc;
                        r_drop <= 1'b1;
                    end
                end
                WAIT: begin
                    if (redirect_valid) r_pc <= w_redir_pc;
                    if (imem_rvalid) begin
                        if (r_drop || redirect_valid) begin
                            r_drop  <= 1'b0;
                            r_state <= FETCH;
                            r_req   <= 1'b1;
                        end else begin
                            r_inst       <= imem_rdata;
                            r_inst_pc    <= r_pc;
                            r_inst_valid <= 1'b1;
                            r_state      <= HOLD;
                        end
                    end else if (redirect_valid) begin
                        r_drop <= 1'b1;
                    end
                end
                HOLD: begin
                    if (inst_ready || redirect_valid) begin
                        r_inst_valid <= 1'b0;
                        r_state      <= FETCH;
                        r_req        <= 1'b1;
                        r_pc         <= redirect_valid ? w_redir_pc : r_pc + 32'd4;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: randomized fetch-stage bench with a transaction-level reference model and directed pins
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [31:0] pc_plus4;
    logic [5:0]  op;
    logic [5:0]  func;

    int checks = 0;
    int errors = 0;

    // environment knobs and memory responder state (owned by the stimulus process)
    logic        nrst = 1'b0;
    int          min_lat = 1;
    int          max_lat = 1;
    logic        stray = 1'b0;
    logic        m_pend = 1'b0;
    int          m_cnt = 0;
    logic [31:0] m_addr = 32'd0;

    // reference model state (owned by the checker process)
    logic        md_started = 1'b0;
    logic        md_idle = 1'b0;
    logic        md_req_due = 1'b0;
    logic        md_inflight = 1'b0;
    logic        md_squash = 1'b0;
    logic        md_hold = 1'b0;
    logic [31:0] md_pc = 32'd0;
    logic [31:0] md_inst = 32'd0;
    logic [31:0] md_hpc = 32'd0;

    fetch_stage dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst(inst), .inst_pc(inst_pc), .pc_plus4(pc_plus4),
        .op(op), .func(func)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a == 32'h0) ? 32'h2008_0005 : (a * 32'h9E37_79B9) ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // one clock cycle: drive inputs after the edge, let memory see any request at the negedge
    task automatic step(input logic rdy, input logic rd, input logic [31:0] tgt);
        @(posedge clk);
        #1;
        rst_n          = nrst;
        inst_ready     = rdy;
        redirect_valid = rd;
        redirect_pc    = tgt;
        imem_rvalid    = 1'b0;
        imem_rdata     = $urandom;
        if (m_pend) begin
            m_cnt--;
            if (m_cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = memf(m_addr);
                m_pend      = 1'b0;
            end
        end else if (stray && $urandom_range(0, 7) == 0) begin
            imem_rvalid = 1'b1;
        end
        @(negedge clk);
        if (imem_req) begin
            m_pend = 1'b1;
            m_addr = imem_addr;
            m_cnt  = $urandom_range(min_lat, max_lat);
        end
    endtask

    task automatic until_req(input logic rdy);
        int n = 0;
        do begin step(rdy, 1'b0, 32'd0); n++; end while (!imem_req && n < 30);
        chk("req_timeout", {31'd0, imem_req}, 32'd1);
    endtask

    task automatic until_valid(input logic rdy);
        int n = 0;
        do begin step(rdy, 1'b0, 32'd0); n++; end while (!inst_valid && n < 30);
        chk("valid_timeout", {31'd0, inst_valid}, 32'd1);
    endtask

    // reference model: compare this cycle's outputs, then advance by this cycle's inputs
    always @(negedge clk) begin : model
        logic nxt;
        if (!rst_n) begin
            chk("rst_req", {31'd0, imem_req}, 32'd0);
            chk("rst_valid", {31'd0, inst_valid}, 32'd0);
            chk("rst_inst", inst, 32'd0);
            chk("rst_inst_pc", inst_pc, 32'd0);
            chk("rst_pc_plus4", pc_plus4, 32'd4);
            chk("rst_op_func", {20'd0, op, func}, 32'd0);
            md_started  = 1'b1;
            md_idle     = 1'b1;
            md_req_due  = 1'b0;
            md_inflight = 1'b0;
            md_squash   = 1'b0;
            md_hold     = 1'b0;
            md_pc       = 32'h0000_0000;
        end else if (md_started) begin
            chk("m_req", {31'd0, imem_req}, {31'd0, md_req_due});
            if (md_req_due) chk("m_addr", imem_addr, md_pc);
            chk("m_valid", {31'd0, inst_valid}, {31'd0, md_hold});
            if (md_hold) begin
                chk("m_inst", inst, md_inst);
                chk("m_inst_pc", inst_pc, md_hpc);
                chk("m_pc_plus4", pc_plus4, md_hpc + 32'd4);
                chk("m_op", {26'd0, op}, {26'd0, md_inst[31:26]});
                chk("m_func", {26'd0, func}, {26'd0, md_inst[5:0]});
            end
            nxt     = md_idle;
            md_idle = 1'b0;
            if (md_hold && (inst_ready || redirect_valid)) begin
                md_hold = 1'b0;
                nxt     = 1'b1;
                md_pc   = md_pc + 32'd4;
            end
            if (md_req_due) begin
                md_inflight = 1'b1;
                md_squash   = 1'b0;
            end else if (md_inflight && imem_rvalid) begin
                md_inflight = 1'b0;
                if (md_squash || redirect_valid) nxt = 1'b1;
                else begin
                    md_hold = 1'b1;
                    md_inst = imem_rdata;
                    md_hpc  = md_pc;
                end
                md_squash = 1'b0;
            end
            if (redirect_valid) begin
                md_pc = redirect_pc & ~32'd3;
                if (md_inflight) md_squash = 1'b1;
            end
            md_req_due = nxt;
        end
    end

    initial begin
        logic [31:0] addrs[$];
        int          nval;
        // reset, then latency-1 memory with decode always ready
        nrst = 1'b0;
        repeat (3) step(1'b0, 1'b0, 32'd0);
        nrst = 1'b1;
        nval = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 32'd0);
            if (imem_req) addrs.push_back(imem_addr);
            if (inst_valid) begin
                if (nval == 0) begin
                    chk("pin_first_inst", inst, 32'h2008_0005);
                    chk("pin_first_op", {26'd0, op}, 32'h0000_0008);
                    chk("pin_first_pc4", pc_plus4, 32'h0000_0004);
                end
                nval++;
            end
        end
        chk("pin_nreq", addrs.size(), 32'd3);
        if (addrs.size() == 3) begin
            chk("pin_addr0", addrs[0], 32'h0);
            chk("pin_addr1", addrs[1], 32'h4);
            chk("pin_addr2", addrs[2], 32'h8);
        end
        chk("pin_nvalid", nval, 32'd3);
        // latency 4, decode stalls in HOLD
        min_lat = 4; max_lat = 4;
        until_valid(1'b0);
        chk("pin_hold_pc", inst_pc, 32'hC);
        chk("pin_hold_inst", inst, memf(32'hC));
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 32'd0);
            chk("pin_stable_valid", {31'd0, inst_valid}, 32'd1);
            chk("pin_stable_pc", inst_pc, 32'hC);
            chk("pin_stable_inst", inst, memf(32'hC));
            chk("pin_stall_noreq", {31'd0, imem_req}, 32'd0);
        end
        step(1'b1, 1'b0, 32'd0);
        step(1'b0, 1'b0, 32'd0);
        chk("pin_after_hs_req", {31'd0, imem_req}, 32'd1);
        chk("pin_after_hs_addr", imem_addr, 32'h10);
        // redirect while waiting: response dropped
        step(1'b1, 1'b1, 32'h0000_0103);
        nval = 0;
        for (int n = 0; n < 30; n++) begin
            step(1'b1, 1'b0, 32'd0);
            if (inst_valid) nval++;
            if (imem_req) break;
        end
        chk("pin_redir_req", {31'd0, imem_req}, 32'd1);
        chk("pin_redir_addr", imem_addr, 32'h100);
        chk("pin_redir_novalid", nval, 32'd0);
        // redirect and handshake in the same HOLD cycle
        min_lat = 2; max_lat = 2;
        step(1'b0, 1'b1, 32'h10);
        until_valid(1'b0);
        chk("pin_rh_pc", inst_pc, 32'h10);
        step(1'b1, 1'b1, 32'h40);
        step(1'b0, 1'b0, 32'd0);
        chk("pin_rh_req", {31'd0, imem_req}, 32'd1);
        chk("pin_rh_addr", imem_addr, 32'h40);
        chk("pin_rh_consumed", {31'd0, inst_valid}, 32'd0);
        // PC wrap at the top of the address space
        min_lat = 4; max_lat = 4;
        step(1'b0, 1'b1, 32'hFFFF_FFFC);
        until_valid(1'b0);
        chk("pin_wrap_pc", inst_pc, 32'hFFFF_FFFC);
        chk("pin_wrap_pc4", pc_plus4, 32'h0);
        step(1'b1, 1'b0, 32'd0);
        step(1'b0, 1'b0, 32'd0);
        chk("pin_wrap_req", {31'd0, imem_req}, 32'd1);
        chk("pin_wrap_addr", imem_addr, 32'h0);
        // reset pulse during WAIT, stale response lands just after release
        nrst = 1'b0;
        step(1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b0, 32'd0);
        nrst = 1'b1;
        step(1'b1, 1'b0, 32'd0);
        chk("pin_rst_idle_noreq", {31'd0, imem_req}, 32'd0);
        step(1'b1, 1'b0, 32'd0);
        chk("pin_rst_stale_rvalid", {31'd0, imem_rvalid}, 32'd1);
        chk("pin_rst_req", {31'd0, imem_req}, 32'd1);
        chk("pin_rst_addr", imem_addr, 32'h0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 32'd0);
            chk("pin_rst_novalid", {31'd0, inst_valid}, 32'd0);
        end
        step(1'b1, 1'b0, 32'd0);
        chk("pin_rst_valid", {31'd0, inst_valid}, 32'd1);
        chk("pin_rst_inst_pc", inst_pc, 32'h0);
        // randomized traffic against the model
        min_lat = 1; max_lat = 5; stray = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (i % 700 == 350) begin
                nrst = 1'b0;
                step(1'b0, 1'b0, 32'd0);
                step(1'b0, 1'b0, 32'd0);
                nrst = 1'b1;
            end
            step($urandom_range(0, 9) < 6, $urandom_range(0, 9) == 0, $urandom);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage for the MIPS core, directly upstream of the opi/opr/inst decoders.
- Owns the PC register and issues one-outstanding-request reads to instruction memory (variable latency).
- Holds each returned word under a valid/ready handshake to decode, with op and func fields pre-split for the decoders.
- Accepts branch/jump redirects from later stages (beq, bne, bltz, j, jal, jr) and squashes any wrong-path fetch.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- imem_req  out  1  one-cycle read request pulse
- imem_addr  out  32  word-aligned read address, valid when imem_req=1
- imem_rvalid  in  1  read data valid, one cycle, any latency >=1 after imem_req
- imem_rdata  in  32  instruction word
- redirect_valid  in  1  branch/jump taken, one-cycle pulse
- redirect_pc  in  32  target PC; bits [1:0] ignored (forced to 00)
- inst_valid  out  1  instruction held for decode
- inst_ready  in  1  decode accepts instruction
- inst  out  32  held instruction word
- inst_pc  out  32  PC of held instruction
- pc_plus4  out  32  inst_pc + 4 (jal link value)
- op  out  6  inst[31:26], to opi/inst decoders
- func  out  6  inst[5:0], to opr decoder

Behaviour:
- Reset (async, rst_n=0): state=IDLE, pc=RESET_PC, drop=0, imem_req=0, inst_valid=0, inst=0, inst_pc=0. op, func and pc_plus4 are combinational from the inst/inst_pc registers, so they reset to 0, 0 and 4.
- IDLE: lasts exactly one cycle after rst_n deasserts, then goes to FETCH.
- FETCH: imem_req=1 and imem_addr=pc for exactly this cycle, then go to WAIT.
- WAIT: imem_req=0. On imem_rvalid:
  - drop=0: latch inst<=imem_rdata and inst_pc<=pc, set inst_valid, go to HOLD.
  - drop=1: discard data, clear drop, go to FETCH.
- HOLD: inst, inst_pc and inst_valid stay stable until inst_ready=1. On the handshake: pc<=pc+4, inst_valid<=0, go to FETCH.
- Latency: min 3 cycles per instruction (FETCH, WAIT with rvalid, HOLD with ready), plus memory latency beyond 1.
- imem_rvalid outside WAIT is ignored.
- Redirect has priority over the sequential PC update in every state; pc<=redirect_pc with bits [1:0]=00.
  - In IDLE: next state FETCH with the new pc.
  - In FETCH: the old-PC request is already issued; go to WAIT with drop=1.
  - In WAIT: set drop=1 and remain in WAIT. If rvalid arrives in the same cycle, discard it, clear drop, go to FETCH.
  - In HOLD without inst_ready: inst_valid<=0 (instruction squashed, never consumed), go to FETCH.
  - In HOLD with inst_ready in the same cycle: the handshake completes and the instruction is consumed, but next pc=redirect_pc, not pc+4.
  - Back-to-back redirects: the last one wins; drop stays 1 until the in-flight response returns.
- PC arithmetic: 32-bit modulo, so 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- rst_n asserted mid-operation: immediate return to reset values. A pending memory response is then ignored, because the state is not WAIT.
- Exactly one outstanding request at any time; imem_req never asserts in WAIT or HOLD.

Test Plan:
- Reset release, memory latency 1, inst_ready tied 1, words at 0x0/0x4/0x8 -> imem_addr sequence 0x0, 0x4, 0x8; inst_valid every 3rd cycle. For inst=32'h2008_0005: op=6'b001000, pc_plus4=0x4.
- Memory latency 4, inst_ready held low 5 cycles in HOLD -> inst and inst_pc stable throughout; no imem_req until the handshake; next imem_addr = inst_pc+4.
- redirect_valid in WAIT with redirect_pc=0x0000_0103 -> returning word discarded with no inst_valid; next imem_addr=0x0000_0100.
- Redirect and inst_ready in the same HOLD cycle at inst_pc=0x10, target 0x40 -> instruction consumed once; next imem_addr=0x40, not 0x14.
- PC=32'hFFFF_FFFC fetched and accepted -> next imem_addr=0x0.
- rst_n pulsed low during WAIT, with rvalid arriving 1 cycle after release -> response ignored; first post-reset imem_addr=RESET_PC; inst_valid stays 0 until that fetch returns.
